round_sat_pipe: RTL and testbench
=================================

// Module: round_sat_pipe
// PURPOSE
//  Pipelined, parametrised fixed-point rounding/saturation stage: drops CUT=DATA_WIDTH-RES_WIDTH LSBs
//  with a run-time-selectable rounding mode, saturates on overflow, and carries valid/ready flow control.
//  Sits between wide accumulators (interpolator, feed-rate math) and narrower step/DAC datapaths.
//  Counts saturation events for diagnostics.
// PARAMETERS
//  DATA_WIDTH  32  input word width
//  RES_WIDTH   24  result width; RES_WIDTH<=DATA_WIDTH; equal -> pass-through (no rounding, never sat)
//  SIGNED      1   1: two's complement in/out; 0: unsigned
//  CNT_WIDTH   16  width of saturation event counter
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  aclr_n     in   1           asynchronous active-low reset
//  in_valid   in   1           input word valid
//  in_ready   out  1           block accepts input this cycle
//  in_data    in   DATA_WIDTH  word to round
//  in_mode    in   2           0 TRUNC(floor) 1 HALF_UP(ties->+inf) 2 HALF_EVEN 3 HALF_AWAY(ties away from 0)
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  out_data   out  RES_WIDTH   rounded, saturated result
//  out_sat    out  1           this result was clamped
//  sat_cnt    out  CNT_WIDTH   number of clamped results delivered, sticks at all-ones
//  sat_clr    in   1           synchronous clear of sat_cnt
// BEHAVIOUR
//  - Reset (async, aclr_n=0): out_valid=0, out_data=0, out_sat=0, sat_cnt=0, both stage valids=0.
//    Reset mid-flight discards all in-pipe words; no partial output after release.
//  - Two register stages; latency exactly 2 cycles from accepted input to out_valid when unstalled.
//    S1: capture in_data/in_mode; compute q=data>>>CUT (floor), g=data[CUT-1], st=|data[CUT-2:0] (0 if CUT=1).
//    S2: inc = mode0:0 | mode1:g | mode2:g&(st|q[0]) | mode3:g&(st|~neg). neg=SIGNED&data[MSB].
//      r = q+inc in RES_WIDTH+1 bits; clamp to MAX/MIN of RES_WIDTH (signed: 0x7F..F/0x80..0;
//      unsigned: all-ones/0); out_sat=1 iff r out of range. Only +1 overflow is possible (floor never underflows).
//  - in_mode is sampled with the accepted word; changing it never affects in-flight words.
//  - Flow control: stall = out_valid & ~out_ready; in_ready = ~stall (combinational from out_ready).
//    When stall: all stage registers hold, out_data/out_sat stable, no word lost or duplicated.
//    Otherwise pipe advances each cycle; bubbles (in_valid=0) propagate as valid=0. Full throughput 1 word/clk.
//  - out_valid/out_data/out_sat never change while out_valid=1 & out_ready=0.
//  - sat_cnt increments on each out_valid&out_ready&out_sat, saturates at 2^CNT_WIDTH-1.
//    sat_clr has priority: same-cycle clear and event -> sat_cnt=0 (event not counted).
//  - Pass-through (CUT=0): out_data=in_data resized, out_sat=0, same 2-cycle latency and handshake.
// TESTING  (DATA_WIDTH=8, RES_WIDTH=4, SIGNED=1, Q4.4 -> Q4.0 unless stated)
//  - Ties: 0x18(1.5) modes0..3 -> 1,2,2,2; 0x28(2.5) -> 2,3,2,3; 0xE8(-1.5) -> 0xE,0xF,0xE,0xE.
//  - Non-tie: 0x1C(1.75) all modes except TRUNC -> 2; 0xE4(-1.75) TRUNC -> 0xE, HALF_UP -> 0xE.
//  - Saturation: 0x7F mode1 -> 0x7, out_sat=1, sat_cnt 0->1; 0x80 mode0 -> 0x8, out_sat=0.
//  - Unsigned (SIGNED=0): 0xF8 mode1 -> 0xF, out_sat=1; 0xF7 mode1 -> 0xF, out_sat=0.
//  - Backpressure: stream 0x10,0x20,...,0x70 back-to-back with out_ready random 50% -> outputs
//    1..7 in order, none dropped/duplicated, out_data stable during every stall; out_ready=1 -> latency 2.
//  - Reset/clear: assert aclr_n=0 with 2 words in flight -> out_valid=0 immediately, no output after
//    release; sat_clr coincident with sat event -> sat_cnt=0; 2^CNT_WIDTH+3 sat events -> sat_cnt all-ones.

Source files
------------

// File: rtl/round_sat_pipe.sv
// round_sat_pipe
//   Two-stage fixed-point rounding and saturation stage with valid/ready flow
//   control. It drops CUT = DATA_WIDTH - RES_WIDTH LSBs using the rounding mode
//   sampled with each word, clamps the result on overflow, and counts clamped
//   results that are delivered downstream.
//
// Ports
//   clk        clock, rising edge
//   aclr_n     asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block accepts input this cycle (combinational from out_ready)
//   in_data    word to round, DATA_WIDTH bits
//   in_mode    0 TRUNC(floor), 1 HALF_UP, 2 HALF_EVEN, 3 HALF_AWAY
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   rounded, saturated result, RES_WIDTH bits
//   out_sat    this result was clamped
//   sat_cnt    clamped results delivered; sticks at all-ones
//   sat_clr    synchronous clear of sat_cnt (wins over a same-cycle event)
module round_sat_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 24,
    parameter int SIGNED     = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  sat_cnt,
    input  logic                  sat_clr
);

    localparam int CUT = DATA_WIDTH - RES_WIDTH;

    // Largest representable result; the floor never underflows, so only the
    // upper bound is ever needed for clamping.
    localparam logic [RES_WIDTH-1:0] SAT_MAX =
        (SIGNED != 0) ? ({RES_WIDTH{1'b1}} >> 1) : {RES_WIDTH{1'b1}};

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- stage 1: split word into floor / guard / sticky ----------------
    logic [RES_WIDTH-1:0] q_d;
    logic                 g_d;
    logic                 st_d;
    logic                 neg_d;

    generate
        if (CUT == 0) begin : g_pass
            assign q_d  = in_data;
            assign g_d  = 1'b0;
            assign st_d = 1'b0;
        end else if (CUT == 1) begin : g_cut1
            assign q_d  = in_data[DATA_WIDTH-1:1];
            assign g_d  = in_data[0];
            assign st_d = 1'b0;
        end else begin : g_cutn
            // Upper bits alone are the arithmetic-shift floor in RES_WIDTH bits.
            assign q_d  = in_data[DATA_WIDTH-1:CUT];
            assign g_d  = in_data[CUT-1];
            assign st_d = |in_data[CUT-2:0];
        end
    endgenerate

    assign neg_d = (SIGNED != 0) && in_data[DATA_WIDTH-1];

    logic                 s1_vld;
    logic [RES_WIDTH-1:0] s1_q;
    logic                 s1_g;
    logic                 s1_st;
    logic                 s1_neg;
    logic [1:0]           s1_mode;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_vld  <= 1'b0;
            s1_q    <= '0;
            s1_g    <= 1'b0;
            s1_st   <= 1'b0;
            s1_neg  <= 1'b0;
            s1_mode <= 2'd0;
        end else if (!stall) begin
            s1_vld  <= in_valid;
            s1_q    <= q_d;
            s1_g    <= g_d;
            s1_st   <= st_d;
            s1_neg  <= neg_d;
            s1_mode <= in_mode;
        end
    end

    // ---------------- stage 2: increment decision, add, clamp ----------------
    logic                 inc;
    logic                 ext;
    logic [RES_WIDTH:0]   r;
    logic                 ovf;
    logic [RES_WIDTH-1:0] res;

    always_comb begin
        inc = 1'b0;
        case (s1_mode)
            2'd0:    inc = 1'b0;
            2'd1:    inc = s1_g;
            2'd2:    inc = s1_g & (s1_st | s1_q[0]);
            default: inc = s1_g & (s1_st | ~s1_neg);
        endcase
    end

    always_comb begin
        ext = (SIGNED != 0) ? s1_q[RES_WIDTH-1] : 1'b0;
        r   = {ext, s1_q} + {{RES_WIDTH{1'b0}}, inc};
        // Signed overflow shows as the two top bits disagreeing; unsigned as a carry out.
        ovf = (SIGNED != 0) ? (r[RES_WIDTH] != r[RES_WIDTH-1]) : r[RES_WIDTH];
        res = ovf ? SAT_MAX : r[RES_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_vld;
            out_data  <= res;
            out_sat   <= s1_vld & ovf;
        end
    end

    // ---------------- saturation event counter ----------------
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_round_sat_pipe.sv
// tb_round_sat_pipe
//   Bench for round_sat_pipe. Three instances share one stimulus stream:
//   signed Q4.4->Q4.0, unsigned 8->4, and an 8->8 pass-through. Directed
//   spec vectors plus randomized traffic checked against an integer model.
module tb_round_sat_pipe;

    logic       clk;
    logic       aclr_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       out_ready;
    logic       sat_clr;

    logic       s_in_ready, u_in_ready, p_in_ready;
    logic       s_valid, u_valid, p_valid;
    logic [3:0] s_data, u_data;
    logic [7:0] p_data;
    logic       s_sat, u_sat, p_sat;
    logic [3:0] s_cnt, u_cnt, p_cnt;

    int checks = 0;
    int errors = 0;

    round_sat_pipe #(.DATA_WIDTH(8), .RES_WIDTH(4), .SIGNED(1), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(s_valid), .out_ready(out_ready),
        .out_data(s_data), .out_sat(s_sat), .sat_cnt(s_cnt), .sat_clr(sat_clr));

    round_sat_pipe #(.DATA_WIDTH(8), .RES_WIDTH(4), .SIGNED(0), .CNT_WIDTH(4)) dut_u (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(u_valid), .out_ready(out_ready),
        .out_data(u_data), .out_sat(u_sat), .sat_cnt(u_cnt), .sat_clr(sat_clr));

    round_sat_pipe #(.DATA_WIDTH(8), .RES_WIDTH(8), .SIGNED(1), .CNT_WIDTH(4)) dut_p (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(p_valid), .out_ready(out_ready),
        .out_data(p_data), .out_sat(p_sat), .sat_cnt(p_cnt), .sat_clr(sat_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round the real value v / 2^cut with plain integer arithmetic.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m,
                                         input bit sgn, input int res, output logic sat);
        int cut, v, q, frac, half, r, mx, mn;
        bit inc;
        cut  = 8 - res;
        v    = sgn ? int'($signed(d)) : int'(d);
        q    = v >>> cut;
        frac = v - (q << cut);
        half = (cut == 0) ? 0 : (1 << (cut - 1));
        inc  = 1'b0;
        case (m)
            2'd0: inc = 1'b0;
            2'd1: inc = (cut > 0) && (frac >= half);
            2'd2: inc = (frac > half) || ((cut > 0) && (frac == half) && q[0]);
            default: inc = (frac > half) || ((cut > 0) && (frac == half) && (v >= 0));
        endcase
        r   = q + int'(inc);
        mx  = sgn ? (1 << (res - 1)) - 1 : (1 << res) - 1;
        mn  = sgn ? -(1 << (res - 1)) : 0;
        sat = (r > mx) || (r < mn);
        if (r > mx) r = mx;
        if (r < mn) r = mn;
        return 8'(r);
    endfunction

    // Present one word with out_ready=1 and wait for it on the signed output.
    task automatic run_word(input logic [7:0] d, input logic [1:0] m, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom); in_mode = 2'($urandom);
        lat = 1;
        while (!s_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        aclr_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0;
        out_ready = 1'b1; sat_clr = 1'b0;
        #12;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", s_valid); end
        checks++; if (s_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", s_data); end
        checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", s_sat); end
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", s_cnt); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", s_in_ready); end
        @(negedge clk); aclr_n = 1'b1;
    endtask

    // {data, mode, expected result, expected sat}
    localparam logic [14:0] TBL [20] = '{
        {8'h18, 2'd0, 4'h1, 1'b0}, {8'h18, 2'd1, 4'h2, 1'b0}, {8'h18, 2'd2, 4'h2, 1'b0}, {8'h18, 2'd3, 4'h2, 1'b0},
        {8'h28, 2'd0, 4'h2, 1'b0}, {8'h28, 2'd1, 4'h3, 1'b0}, {8'h28, 2'd2, 4'h2, 1'b0}, {8'h28, 2'd3, 4'h3, 1'b0},
        {8'hE8, 2'd0, 4'hE, 1'b0}, {8'hE8, 2'd1, 4'hF, 1'b0}, {8'hE8, 2'd2, 4'hE, 1'b0}, {8'hE8, 2'd3, 4'hE, 1'b0},
        {8'h1C, 2'd0, 4'h1, 1'b0}, {8'h1C, 2'd1, 4'h2, 1'b0}, {8'h1C, 2'd2, 4'h2, 1'b0}, {8'h1C, 2'd3, 4'h2, 1'b0},
        {8'hE4, 2'd0, 4'hE, 1'b0}, {8'hE4, 2'd1, 4'hE, 1'b0},
        {8'h7F, 2'd1, 4'h7, 1'b1}, {8'h80, 2'd0, 4'h8, 1'b0}
    };

    task automatic test_directed();
        logic [14:0] v;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = TBL[i];
            run_word(v[14:7], v[6:5], lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (s_data !== v[4:1]) begin errors++; $display("FAIL dir_data[%0d] in=%0h mode=%0d: got %0h expected %0h", i, v[14:7], v[6:5], s_data, v[4:1]); end
            checks++; if (s_sat !== v[0]) begin errors++; $display("FAIL dir_sat[%0d]: got %0b expected %0b", i, s_sat, v[0]); end
            checks++; if (p_data !== v[14:7] || p_sat !== 1'b0) begin errors++; $display("FAIL dir_pass[%0d]: got %0h/%0b expected %0h/0", i, p_data, p_sat, v[14:7]); end
        end
    endtask

    task automatic test_unsigned();
        int lat;
        run_word(8'hF8, 2'd1, lat);
        checks++; if (u_data !== 4'hF || u_sat !== 1'b1) begin errors++; $display("FAIL uns_F8: got %0h/%0b expected f/1", u_data, u_sat); end
        run_word(8'hF7, 2'd1, lat);
        checks++; if (u_data !== 4'hF || u_sat !== 1'b0) begin errors++; $display("FAIL uns_F7: got %0h/%0b expected f/0", u_data, u_sat); end
    endtask

    task automatic test_sat_count();
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1; sat_clr = 1'b1;
        @(posedge clk); #1; sat_clr = 1'b0;
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL cnt_clear: got %0h expected 0", s_cnt); end
        run_word(8'h7F, 2'd1, lat);
        @(posedge clk); #1;
        checks++; if (s_cnt !== 4'h1) begin errors++; $display("FAIL cnt_one: got %0h expected 1", s_cnt); end
        // Clear lands in the same cycle as the next delivered saturation.
        run_word(8'h7F, 2'd1, lat);
        sat_clr = 1'b1;
        @(posedge clk); #1; sat_clr = 1'b0;
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL cnt_clr_priority: got %0h expected 0", s_cnt); end
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'h7F; in_mode = 2'd1;
        end
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL cnt_stick: got %0h expected f", s_cnt); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0;
        logic prev_stall = 1'b0;
        logic [3:0] prev_data = 4'h0;
        while (got < 7 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 7);
            in_data   = 8'((sent + 1) * 16);
            in_mode   = 2'($urandom);
            @(negedge clk);
            if (in_valid && s_in_ready) sent++;
            if (prev_stall) begin
                checks++;
                if (!s_valid || s_data !== prev_data) begin errors++; $display("FAIL bp_stable: got %0b/%0h expected 1/%0h", s_valid, s_data, prev_data); end
            end
            if (s_valid && out_ready) begin
                checks++;
                if (s_data !== 4'(got + 1)) begin errors++; $display("FAIL bp_order: got %0h expected %0h", s_data, 4'(got + 1)); end
                got++;
            end
            prev_stall = s_valid && !out_ready;
            prev_data  = s_data;
        end
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 7) begin errors++; $display("FAIL bp_count: got %0d expected 7", got); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_extra: got %0b expected 0", s_valid); end
    endtask

    task automatic test_random();
        logic [8:0] qs[$], qu[$], qp[$];
        logic [8:0] e;
        logic [7:0] r;
        logic sat;
        logic prev_stall = 1'b0;
        logic [3:0] prev_data = 4'h0;
        for (int cyc = 0; cyc < 520; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 500) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (cyc < 500) && ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_mode   = 2'($urandom);
            @(negedge clk);
            if (in_valid && s_in_ready) begin
                r = model(in_data, in_mode, 1'b1, 4, sat); qs.push_back({sat, r});
                r = model(in_data, in_mode, 1'b0, 4, sat); qu.push_back({sat, r});
                r = model(in_data, in_mode, 1'b1, 8, sat); qp.push_back({sat, r});
            end
            if (prev_stall) begin
                checks++;
                if (!s_valid || s_data !== prev_data) begin errors++; $display("FAIL rnd_stable: got %0b/%0h expected 1/%0h", s_valid, s_data, prev_data); end
            end
            if (s_valid && out_ready) begin
                checks++;
                if (qs.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected: got %0h expected none", s_data);
                end else begin
                    e = qs.pop_front();
                    if (s_data !== e[3:0] || s_sat !== e[8]) begin errors++; $display("FAIL rnd_signed: got %0h/%0b expected %0h/%0b", s_data, s_sat, e[3:0], e[8]); end
                    e = qu.pop_front();
                    if (u_data !== e[3:0] || u_sat !== e[8]) begin errors++; $display("FAIL rnd_unsigned: got %0h/%0b expected %0h/%0b", u_data, u_sat, e[3:0], e[8]); end
                    e = qp.pop_front();
                    if (p_data !== e[7:0] || p_sat !== e[8]) begin errors++; $display("FAIL rnd_pass: got %0h/%0b expected %0h/%0b", p_data, p_sat, e[7:0], e[8]); end
                end
            end
            prev_stall = s_valid && !out_ready;
            prev_data  = s_data;
        end
        checks++; if (qs.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d left expected 0", qs.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h30; in_mode = 2'd0;
        @(posedge clk); #1; in_data = 8'h40;
        @(posedge clk); #1; in_valid = 1'b0;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL mid_before: got %0b expected 1", s_valid); end
        aclr_n = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0 || s_data !== 4'h0) begin errors++; $display("FAIL mid_async: got %0b/%0h expected 0/0", s_valid, s_data); end
        checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL mid_cnt: got %0h expected 0", s_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk); aclr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_after[%0d]: got %0b expected 0", i, s_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_unsigned();
        test_sat_count();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
